// File: rtl/cart_burst_capture_pkg.sv
// Shared definitions for the cart burst capture block.
//   state_e         : burst tracker FSM states
//   calc_sample_dly : clock cycles between a detected RD fall and valid AD data
package cart_burst_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR_H = 2'd1,
    ST_ADDR_L = 2'd2,
    ST_BURST  = 2'd3
  } state_e;

  // One extra cycle on top of the truncated nanosecond delay guarantees
  // that the AD bus has settled before it is captured.
  function automatic int calc_sample_dly(input int clk_freq, input int data_delay_ns);
    return (data_delay_ns * (clk_freq / 1_000_000)) / 1000 + 1;
  endfunction

endpackage

// File: rtl/cart_burst_capture_fifo.sv
// Synchronous first-word-fall-through FIFO for captured cart records.
//   clk, reset : system clock, asynchronous active-high reset
//   wr_en      : write request; accepted when not full, or when full and a read happens
//   wr_data    : record to store
//   rd_en      : read request; ignored while empty
//   rd_data    : head record, forced to zero while empty
//   full/empty : occupancy flags
module cart_burst_capture_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A read in the same cycle frees a slot, so a write while full still lands.
  always_comb begin
    do_rd    = rd_en && !empty;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Zero while empty keeps the consumer-facing outputs at their reset values.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/cart_burst_capture.sv
// N64 cart PI burst snooper. Follows one ALE_H/ALE_L address phase plus any
// number of RD strobes, assembles halfwords into words and queues one
// {address, data, last} record per word in an output FIFO.
//   clk, reset          : system clock, asynchronous active-high reset
//   cart_ad/rd/alel/aleh: raw cart bus, asynchronous to clk
//   m_valid/m_ready     : record handshake, FIFO head shown first-word-fall-through
//   m_addr/m_data/m_last: record fields
//   ovf_cnt             : saturating count of records dropped on a full FIFO
//   busy                : tracker has left IDLE
module cart_burst_capture
  import cart_burst_capture_pkg::*;
#(
  parameter int CLK_FREQ      = 25_000_000,
  parameter int DATA_DELAY_NS = 100,
  parameter int HW_PER_WORD   = 2,
  parameter int HI_FIRST      = 0,
  parameter int FIFO_DEPTH    = 16,
  parameter int OVF_W         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [15:0]               cart_ad,
  input  logic                      cart_rd,
  input  logic                      cart_alel,
  input  logic                      cart_aleh,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [31:0]               m_addr,
  output logic [16*HW_PER_WORD-1:0] m_data,
  output logic                      m_last,
  output logic [OVF_W-1:0]          ovf_cnt,
  output logic                      busy
);

  localparam int          DW         = 16 * HW_PER_WORD;
  localparam int          REC_W      = 32 + DW + 1;
  localparam int          SAMPLE_DLY = calc_sample_dly(CLK_FREQ, DATA_DELAY_NS);
  localparam logic [1:0]  LAST_HW    = 2'(HW_PER_WORD - 1);
  localparam logic [31:0] ADDR_STEP  = 32'(2 * HW_PER_WORD);
  // Synchronizer bundle {aleh, alel, rd, ad}; idle bus means RD high, ALEs low.
  localparam logic [18:0] SYNC_IDLE  = {1'b0, 1'b0, 1'b1, 16'h0000};

  logic [18:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic                  rd_prev_q, rd_prev_d;
  logic                  alel_prev_q, alel_prev_d;
  logic                  aleh_prev_q, aleh_prev_d;
  logic [SAMPLE_DLY-1:0] dly_q, dly_d;
  state_e                state_q, state_d;
  logic [31:0]           addr_cur_q, addr_cur_d;
  logic [1:0]            hw_cnt_q, hw_cnt_d;
  logic [DW-1:0]         word_q, word_d;
  logic                  hold_valid_q, hold_valid_d;
  logic [31:0]           hold_addr_q, hold_addr_d;
  logic [DW-1:0]         hold_data_q, hold_data_d;
  logic [OVF_W-1:0]      ovf_cnt_q, ovf_cnt_d;

  logic [15:0]    ad_s;
  logic           rd_s, alel_s, aleh_s;
  logic           rd_fall, aleh_rise, aleh_fall, alel_fall;
  logic           sample;
  logic [1:0]     pos;
  logic [DW-1:0]  word_asm;
  logic           fifo_full, fifo_empty, pop, drop;
  logic [REC_W-1:0] fifo_wr_data, fifo_rd_data;

  assign ad_s   = sync2_q[15:0];
  assign rd_s   = sync2_q[16];
  assign alel_s = sync2_q[17];
  assign aleh_s = sync2_q[18];

  assign rd_fall   = rd_prev_q & ~rd_s;
  assign aleh_rise = aleh_s & ~aleh_prev_q;
  assign aleh_fall = ~aleh_s & aleh_prev_q;
  assign alel_fall = ~alel_s & alel_prev_q;
  assign sample    = dly_q[SAMPLE_DLY-1];

  // The held word is always pushed on the cycle after it completes; it is
  // flagged last only when a new address phase starts in that same cycle.
  assign fifo_wr_data = {hold_addr_q, hold_data_q, aleh_rise};
  assign pop          = m_valid & m_ready;
  assign drop         = hold_valid_q & fifo_full & ~pop;

  // Next-state logic: synchronizer, edge history, delay line, burst FSM,
  // halfword assembly, holding register and overflow counter.
  always_comb begin
    sync1_d      = {cart_aleh, cart_alel, cart_rd, cart_ad};
    sync2_d      = sync1_q;
    rd_prev_d    = rd_s;
    alel_prev_d  = alel_s;
    aleh_prev_d  = aleh_s;
    dly_d        = (dly_q << 1) | SAMPLE_DLY'(rd_fall);
    state_d      = state_q;
    addr_cur_d   = addr_cur_q;
    hw_cnt_d     = hw_cnt_q;
    word_d       = word_q;
    hold_valid_d = 1'b0;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    ovf_cnt_d    = ovf_cnt_q;

    // Halfword slot for this sample; HI_FIRST fills from the top slot down.
    pos      = (HI_FIRST != 0) ? 2'(LAST_HW - hw_cnt_q) : hw_cnt_q;
    word_asm = word_q;
    for (int i = 0; i < HW_PER_WORD; i++) begin
      if (pos == 2'(i)) begin
        word_asm[i*16 +: 16] = ad_s;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (aleh_rise) state_d = ST_ADDR_H;
      end
      ST_ADDR_H: begin
        if (aleh_s) addr_cur_d[31:16] = ad_s;
        if (aleh_fall) state_d = ST_ADDR_L;
      end
      ST_ADDR_L: begin
        if (aleh_rise) begin
          state_d = ST_ADDR_H;
        end else begin
          if (alel_s) addr_cur_d[15:0] = ad_s;
          if (alel_fall) begin
            state_d  = ST_BURST;
            hw_cnt_d = '0;
            word_d   = '0;
          end
        end
      end
      ST_BURST: begin
        // A new address phase wins over a coincident sample and drops any partial word.
        if (aleh_rise) begin
          state_d  = ST_ADDR_H;
          hw_cnt_d = '0;
          word_d   = '0;
        end else if (sample) begin
          if (hw_cnt_q == LAST_HW) begin
            hold_valid_d = 1'b1;
            hold_addr_d  = addr_cur_q;
            hold_data_d  = word_asm;
            addr_cur_d   = addr_cur_q + ADDR_STEP;
            hw_cnt_d     = '0;
            word_d       = '0;
          end else begin
            word_d   = word_asm;
            hw_cnt_d = hw_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (drop && (ovf_cnt_q != {OVF_W{1'b1}})) begin
      ovf_cnt_d = ovf_cnt_q + OVF_W'(1);
    end
  end

  // All state of the block, including the FSM, registers here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= SYNC_IDLE;
      sync2_q      <= SYNC_IDLE;
      rd_prev_q    <= 1'b1;
      alel_prev_q  <= 1'b0;
      aleh_prev_q  <= 1'b0;
      dly_q        <= '0;
      state_q      <= ST_IDLE;
      addr_cur_q   <= '0;
      hw_cnt_q     <= '0;
      word_q       <= '0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      rd_prev_q    <= rd_prev_d;
      alel_prev_q  <= alel_prev_d;
      aleh_prev_q  <= aleh_prev_d;
      dly_q        <= dly_d;
      state_q      <= state_d;
      addr_cur_q   <= addr_cur_d;
      hw_cnt_q     <= hw_cnt_d;
      word_q       <= word_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  cart_burst_capture_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (hold_valid_q),
    .wr_data (fifo_wr_data),
    .rd_en   (m_ready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_valid                  = ~fifo_empty;
  assign {m_addr, m_data, m_last} = fifo_rd_data;
  assign ovf_cnt                  = ovf_cnt_q;
  assign busy                     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cart_burst_capture.sv
// Directed bench for cart_burst_capture. Three instances share the cart bus:
//   dut     : HW_PER_WORD=2, HI_FIRST=0, FIFO_DEPTH=4 (main checks, overflow)
//   dut_hi  : HW_PER_WORD=2, HI_FIRST=1
//   dut_w1  : HW_PER_WORD=1
// Inputs change on the falling clock edge; outputs are checked there too.
module tb_cart_burst_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cart_ad = 16'h0000;
  logic        cart_rd = 1'b1;
  logic        cart_alel = 1'b0;
  logic        cart_aleh = 1'b0;

  logic        m_valid, m_ready = 1'b0, m_last, busy;
  logic [31:0] m_addr, m_data;
  logic [15:0] ovf_cnt;

  logic        hi_valid, hi_ready = 1'b0, hi_last, hi_busy;
  logic [31:0] hi_addr, hi_data;
  logic [15:0] hi_ovf;

  logic        w1_valid, w1_ready = 1'b0, w1_last, w1_busy;
  logic [31:0] w1_addr;
  logic [15:0] w1_data;
  logic [15:0] w1_ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cart_burst_capture #(.HW_PER_WORD(2), .HI_FIRST(0), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cart_ad(cart_ad), .cart_rd(cart_rd),
    .cart_alel(cart_alel), .cart_aleh(cart_aleh),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
    .m_last(m_last), .ovf_cnt(ovf_cnt), .busy(busy)
  );

  cart_burst_capture #(.HW_PER_WORD(2), .HI_FIRST(1), .FIFO_DEPTH(16)) dut_hi (
    .clk(clk), .reset(reset), .cart_ad(cart_ad), .cart_rd(cart_rd),
    .cart_alel(cart_alel), .cart_aleh(cart_aleh),
    .m_valid(hi_valid), .m_ready(hi_ready), .m_addr(hi_addr), .m_data(hi_data),
    .m_last(hi_last), .ovf_cnt(hi_ovf), .busy(hi_busy)
  );

  cart_burst_capture #(.HW_PER_WORD(1), .HI_FIRST(0), .FIFO_DEPTH(16)) dut_w1 (
    .clk(clk), .reset(reset), .cart_ad(cart_ad), .cart_rd(cart_rd),
    .cart_alel(cart_alel), .cart_aleh(cart_aleh),
    .m_valid(w1_valid), .m_ready(w1_ready), .m_addr(w1_addr), .m_data(w1_data),
    .m_last(w1_last), .ovf_cnt(w1_ovf), .busy(w1_busy)
  );

  // Safety net in case some wait is ever left unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Address phase; pass aleh_high when ALE_H was already raised by the last strobe.
  task automatic apply_addr_phase(input logic [31:0] a, input bit aleh_high);
    if (!aleh_high) cart_aleh = 1'b1;
    cart_ad = a[31:16];
    wait_cycles(4);
    cart_aleh = 1'b0;
    wait_cycles(4);
    cart_alel = 1'b1;
    cart_ad   = a[15:0];
    wait_cycles(4);
    cart_alel = 1'b0;
    wait_cycles(4);
  endtask

  // One RD strobe. raise_aleh lifts ALE_H four cycles into the strobe so its
  // detected rise lands in the holding cycle of a word completed by this strobe.
  task automatic apply_stimulus(input logic [15:0] v, input bit raise_aleh);
    cart_ad = v;
    cart_rd = 1'b0;
    wait_cycles(4);
    if (raise_aleh) cart_aleh = 1'b1;
    wait_cycles(2);
    cart_rd = 1'b1;
    wait_cycles(4);
  endtask

  // Wait (bounded) for a head record on instance w, check it, then pop it.
  task automatic pop_rec(input int w, input string tag,
                         input logic [31:0] ea, input logic [31:0] ed, input logic el);
    int n;
    logic v;
    logic [31:0] a, d;
    logic l;
    n = 0;
    v = (w == 0) ? m_valid : (w == 1) ? hi_valid : w1_valid;
    while (!v && n < 200) begin
      @(negedge clk);
      n++;
      v = (w == 0) ? m_valid : (w == 1) ? hi_valid : w1_valid;
    end
    a = (w == 0) ? m_addr : (w == 1) ? hi_addr : w1_addr;
    d = (w == 0) ? m_data : (w == 1) ? hi_data : {16'h0000, w1_data};
    l = (w == 0) ? m_last : (w == 1) ? hi_last : w1_last;
    check_output({tag, "_valid"}, {63'd0, v}, 64'd1);
    check_output({tag, "_addr"}, {32'd0, a}, {32'd0, ea});
    check_output({tag, "_data"}, {32'd0, d}, {32'd0, ed});
    check_output({tag, "_last"}, {63'd0, l}, {63'd0, el});
    if (w == 0) m_ready = 1'b1; else if (w == 1) hi_ready = 1'b1; else w1_ready = 1'b1;
    @(negedge clk);
    if (w == 0) m_ready = 1'b0; else if (w == 1) hi_ready = 1'b0; else w1_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    wait_cycles(3);
    check_output("rst_valid", {63'd0, m_valid}, 64'd0);
    check_output("rst_addr", {32'd0, m_addr}, 64'd0);
    check_output("rst_data", {32'd0, m_data}, 64'd0);
    check_output("rst_last", {63'd0, m_last}, 64'd0);
    check_output("rst_ovf", {48'd0, ovf_cnt}, 64'd0);
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    wait_cycles(3);

    // Burst at 0x10000040 with four halfwords, ended by the next ALE_H
    apply_addr_phase(32'h1000_0040, 1'b0);
    check_output("busy_after_addr", {63'd0, busy}, 64'd1);
    apply_stimulus(16'h1111, 1'b0);
    apply_stimulus(16'h2222, 1'b0);
    apply_stimulus(16'h3333, 1'b0);
    apply_stimulus(16'h4444, 1'b1);
    apply_addr_phase(32'hFFFF_FFFC, 1'b1);

    pop_rec(0, "lo_r0", 32'h1000_0040, 32'h2222_1111, 1'b0);
    pop_rec(0, "lo_r1", 32'h1000_0044, 32'h4444_3333, 1'b1);
    pop_rec(1, "hi_r0", 32'h1000_0040, 32'h1111_2222, 1'b0);
    pop_rec(1, "hi_r1", 32'h1000_0044, 32'h3333_4444, 1'b1);
    pop_rec(2, "w1_r0", 32'h1000_0040, 32'h0000_1111, 1'b0);
    pop_rec(2, "w1_r1", 32'h1000_0042, 32'h0000_2222, 1'b0);
    pop_rec(2, "w1_r2", 32'h1000_0044, 32'h0000_3333, 1'b0);
    pop_rec(2, "w1_r3", 32'h1000_0046, 32'h0000_4444, 1'b1);
    hi_ready = 1'b1;
    w1_ready = 1'b1;

    // Address wrap past 0xFFFFFFFF
    apply_stimulus(16'hAAAA, 1'b0);
    apply_stimulus(16'hBBBB, 1'b0);
    apply_stimulus(16'hCCCC, 1'b0);
    apply_stimulus(16'hDDDD, 1'b0);
    pop_rec(0, "wrap_r0", 32'hFFFF_FFFC, 32'hBBBB_AAAA, 1'b0);
    pop_rec(0, "wrap_r1", 32'h0000_0000, 32'hDDDD_CCCC, 1'b0);

    // Partial word dropped by a new address phase
    apply_addr_phase(32'h2000_0000, 1'b0);
    apply_stimulus(16'h0101, 1'b0);
    apply_stimulus(16'h0202, 1'b0);
    apply_stimulus(16'h0303, 1'b0);
    apply_addr_phase(32'h3000_0010, 1'b0);
    apply_stimulus(16'h0A0A, 1'b0);
    apply_stimulus(16'h0B0B, 1'b0);
    pop_rec(0, "part_r0", 32'h2000_0000, 32'h0202_0101, 1'b0);
    pop_rec(0, "part_r1", 32'h3000_0010, 32'h0B0B_0A0A, 1'b0);

    // Overflow: six words into a 4-deep FIFO with no consumer
    apply_addr_phase(32'h4000_0000, 1'b0);
    for (int k = 0; k < 12; k++) begin
      apply_stimulus(16'h1000 + 16'(k), 1'b0);
    end
    wait_cycles(4);
    check_output("ovf_cnt", {48'd0, ovf_cnt}, 64'd2);
    for (int j = 0; j < 4; j++) begin
      pop_rec(0, $sformatf("ovf_r%0d", j), 32'h4000_0000 + 32'(4 * j),
              {16'h1001 + 16'(2 * j), 16'h1000 + 16'(2 * j)}, 1'b0);
    end
    wait_cycles(2);
    check_output("drain_empty", {63'd0, m_valid}, 64'd0);

    // Asynchronous reset with a queued record and a partial halfword
    apply_addr_phase(32'h5000_0000, 1'b0);
    apply_stimulus(16'h7777, 1'b0);
    apply_stimulus(16'h8888, 1'b0);
    apply_stimulus(16'h9999, 1'b0);
    check_output("pre_rst_valid", {63'd0, m_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check_output("mid_rst_valid", {63'd0, m_valid}, 64'd0);
    check_output("mid_rst_addr", {32'd0, m_addr}, 64'd0);
    check_output("mid_rst_data", {32'd0, m_data}, 64'd0);
    check_output("mid_rst_ovf", {48'd0, ovf_cnt}, 64'd0);
    check_output("mid_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_cycles(3);
    check_output("post_rst_busy", {63'd0, busy}, 64'd0);
    apply_addr_phase(32'h6000_0008, 1'b0);
    apply_stimulus(16'h5555, 1'b0);
    apply_stimulus(16'h6666, 1'b0);
    pop_rec(0, "clean_r0", 32'h6000_0008, 32'h6666_5555, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
